// File: rtl/led_state_monitor.sv
// Watches a 16-lamp flasher bus and classifies its motion as idle, rising, falling or faulted.
// Tracks reversal extremes, completed up/down sequences and sticky shape/step/stall faults.
module led_state_monitor #(
    parameter int STALL_MAX = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      led_state,
    input  logic             clr,
    output logic [4:0]       level,
    output logic [1:0]       dir,
    output logic             reversal,
    output logic [4:0]       peak_level,
    output logic [4:0]       trough_level,
    output logic             seq_done,
    output logic [CNT_W-1:0] seq_cnt,
    output logic             err_shape,
    output logic             err_step,
    output logic             err_stall
);

    localparam int STALL_W = $clog2(STALL_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_UP    = 2'b01,
        ST_DOWN  = 2'b10,
        ST_FAULT = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         level_q, level_d;
    logic               reversal_q, reversal_d;
    logic               seq_done_q, seq_done_d;
    logic [4:0]         peak_q, peak_d;
    logic [4:0]         trough_q, trough_d;
    logic [CNT_W-1:0]   seq_cnt_q, seq_cnt_d;
    logic               err_shape_q, err_shape_d;
    logic               err_step_q, err_step_d;
    logic               err_stall_q, err_stall_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    // One comparator per legal thermometer pattern 2^k-1, k = 0..16.
    logic [16:0] therm_hit;
    genvar gi;
    generate
        for (gi = 0; gi < 17; gi++) begin : g_therm
            localparam logic [16:0] PAT = (17'd1 << gi) - 17'd1;
            assign therm_hit[gi] = ({1'b0, led_state} == PAT);
        end
    endgenerate

    logic       sample_legal;
    logic [4:0] sample_k;

    always_comb begin
        sample_k = 5'd0;
        for (int i = 0; i < 17; i++) begin
            if (therm_hit[i]) begin
                sample_k = 5'(i);
            end
        end
    end

    assign sample_legal = |therm_hit;

    // Widen by one bit so level 16 +/- 1 comparisons cannot wrap.
    logic [5:0] k_ext, lvl_ext;
    logic       step_same, step_up, step_down;
    logic [STALL_W-1:0] stall_inc;

    assign k_ext     = {1'b0, sample_k};
    assign lvl_ext   = {1'b0, level_q};
    assign step_same = (k_ext == lvl_ext);
    assign step_up   = (k_ext == lvl_ext + 6'd1);
    assign step_down = (k_ext + 6'd1 == lvl_ext);
    assign stall_inc = stall_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        reversal_d  = 1'b0;
        seq_done_d  = 1'b0;
        peak_d      = peak_q;
        trough_d    = trough_q;
        seq_cnt_d   = seq_cnt_q;
        err_shape_d = err_shape_q;
        err_step_d  = err_step_q;
        err_stall_d = err_stall_q;
        stall_d     = stall_q;

        if (clr) begin
            err_shape_d = 1'b0;
            err_step_d  = 1'b0;
            err_stall_d = 1'b0;
            stall_d     = '0;
            if (sample_legal) begin
                level_d = sample_k;
                state_d = ST_IDLE;
            end else begin
                err_shape_d = 1'b1;
                state_d     = ST_FAULT;
            end
        end else if (state_q != ST_FAULT) begin
            if (!sample_legal) begin
                err_shape_d = 1'b1;
                state_d     = ST_FAULT;
            end else if (!(step_same || step_up || step_down)) begin
                err_step_d = 1'b1;
                level_d    = sample_k;
                state_d    = ST_FAULT;
            end else if (step_same) begin
                // A parked bus at level 0 in IDLE is normal, not a stall.
                if (state_q != ST_IDLE) begin
                    stall_d = stall_inc;
                    if (stall_inc == STALL_W'(STALL_MAX)) begin
                        err_stall_d = 1'b1;
                        state_d     = ST_FAULT;
                    end
                end
            end else if (step_up) begin
                stall_d = '0;
                level_d = sample_k;
                state_d = ST_UP;
                if (state_q == ST_DOWN) begin
                    reversal_d = 1'b1;
                    trough_d   = level_q;
                end
            end else begin
                stall_d = '0;
                level_d = sample_k;
                if (state_q == ST_UP) begin
                    reversal_d = 1'b1;
                    peak_d     = level_q;
                    state_d    = ST_DOWN;
                end else if (state_q == ST_DOWN && sample_k == 5'd0) begin
                    seq_done_d = 1'b1;
                    state_d    = ST_IDLE;
                    if (seq_cnt_q != '1) begin
                        seq_cnt_d = seq_cnt_q + 1'b1;
                    end
                end else begin
                    state_d = ST_DOWN;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            level_q     <= 5'd0;
            reversal_q  <= 1'b0;
            seq_done_q  <= 1'b0;
            peak_q      <= 5'd0;
            trough_q    <= 5'd0;
            seq_cnt_q   <= '0;
            err_shape_q <= 1'b0;
            err_step_q  <= 1'b0;
            err_stall_q <= 1'b0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            reversal_q  <= reversal_d;
            seq_done_q  <= seq_done_d;
            peak_q      <= peak_d;
            trough_q    <= trough_d;
            seq_cnt_q   <= seq_cnt_d;
            err_shape_q <= err_shape_d;
            err_step_q  <= err_step_d;
            err_stall_q <= err_stall_d;
            stall_q     <= stall_d;
        end
    end

    assign level        = level_q;
    assign dir          = state_q;
    assign reversal     = reversal_q;
    assign seq_done     = seq_done_q;
    assign peak_level   = peak_q;
    assign trough_level = trough_q;
    assign seq_cnt      = seq_cnt_q;
    assign err_shape    = err_shape_q;
    assign err_step     = err_step_q;
    assign err_stall    = err_stall_q;

endmodule

// File: tb/tb_led_state_monitor.sv
// Bench for led_state_monitor: randomized walks checked every cycle against a behavioural model,
// plus directed scenarios pinned with hand-computed literal expectations.
module tb_led_state_monitor;

    localparam int STALL_MAX = 8;
    localparam int CNT_W     = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [15:0]      led_state = 16'h0000;
    logic             clr = 1'b0;
    logic [4:0]       level;
    logic [1:0]       dir;
    logic             reversal;
    logic [4:0]       peak_level;
    logic [4:0]       trough_level;
    logic             seq_done;
    logic [CNT_W-1:0] seq_cnt;
    logic             err_shape;
    logic             err_step;
    logic             err_stall;

    led_state_monitor #(.STALL_MAX(STALL_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .led_state(led_state), .clr(clr),
        .level(level), .dir(dir), .reversal(reversal),
        .peak_level(peak_level), .trough_level(trough_level),
        .seq_done(seq_done), .seq_cnt(seq_cnt),
        .err_shape(err_shape), .err_step(err_step), .err_stall(err_stall)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: mode 0 idle, 1 rising, 2 falling, 3 fault.
    int m_level, m_mode, m_rev, m_done, m_peak, m_trough, m_cnt;
    int m_es, m_est, m_esl, m_stall;

    function automatic int lamp_count(input int s);
        for (int k = 0; k <= 16; k++) begin
            if (s == (1 << k) - 1) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_level = 0; m_mode = 0; m_rev = 0; m_done = 0; m_peak = 0; m_trough = 0;
        m_cnt = 0; m_es = 0; m_est = 0; m_esl = 0; m_stall = 0;
    endtask

    task automatic model_step(input int s, input int c, input int r);
        int k, delta;
        k = lamp_count(s);
        m_rev = 0;
        m_done = 0;
        if (r != 0) begin
            model_reset();
        end else if (c != 0) begin
            m_es = 0; m_est = 0; m_esl = 0; m_stall = 0;
            if (k >= 0) begin
                m_level = k;
                m_mode = 0;
            end else begin
                m_es = 1;
                m_mode = 3;
            end
        end else if (m_mode != 3) begin
            delta = k - m_level;
            if (k < 0) begin
                m_es = 1; m_mode = 3;
            end else if (delta > 1 || delta < -1) begin
                m_est = 1; m_mode = 3; m_level = k;
            end else if (delta == 0) begin
                if (m_mode != 0) begin
                    m_stall++;
                    if (m_stall >= STALL_MAX) begin
                        m_esl = 1; m_mode = 3;
                    end
                end
            end else if (delta == 1) begin
                m_stall = 0;
                if (m_mode == 2) begin
                    m_rev = 1; m_trough = m_level;
                end
                m_mode = 1;
                m_level = k;
            end else begin
                m_stall = 0;
                if (m_mode == 1) begin
                    m_rev = 1; m_peak = m_level; m_mode = 2;
                end else if (m_mode == 2 && k == 0) begin
                    m_done = 1; m_mode = 0;
                    if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                end else begin
                    m_mode = 2;
                end
                m_level = k;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("level", int'(level), m_level);
        chk("dir", int'(dir), m_mode);
        chk("reversal", int'(reversal), m_rev);
        chk("seq_done", int'(seq_done), m_done);
        chk("peak_level", int'(peak_level), m_peak);
        chk("trough_level", int'(trough_level), m_trough);
        chk("seq_cnt", int'(seq_cnt), m_cnt);
        chk("err_shape", int'(err_shape), m_es);
        chk("err_step", int'(err_step), m_est);
        chk("err_stall", int'(err_stall), m_esl);
        chk("pulse_exclusive", int'(reversal & seq_done), 0);
    endtask

    task automatic step(input logic [15:0] s, input logic c, input logic r);
        @(negedge clk);
        led_state = s;
        clr = c;
        rst = r;
        @(posedge clk);
        model_step(int'(s), int'(c), int'(r));
        #1;
        compare_all();
        $display("cyc led=%04h clr=%0d rst=%0d -> level=%0d dir=%0d rev=%0d done=%0d cnt=%0d err=%0d%0d%0d",
                 s, c, r, level, dir, reversal, seq_done, seq_cnt, err_shape, err_step, err_stall);
    endtask

    function automatic logic [15:0] therm(input int k);
        logic [16:0] v;
        v = (17'd1 << k) - 17'd1;
        return v[15:0];
    endfunction

    int revs;
    int g;
    int r;
    logic [15:0] s;

    initial begin
        model_reset();
        step(16'h0000, 1'b0, 1'b1);
        chk("reset_level", int'(level), 0);
        chk("reset_dir", int'(dir), 0);

        // Full ramp to 6 and back down.
        for (int k = 1; k <= 6; k++) begin
            step(therm(k), 1'b0, 1'b0);
            chk("ramp_up_dir", int'(dir), 1);
        end
        for (int k = 5; k >= 0; k--) step(therm(k), 1'b0, 1'b0);
        chk("ramp_seq_done", int'(seq_done), 1);
        chk("ramp_peak", int'(peak_level), 6);
        chk("ramp_cnt", int'(seq_cnt), 1);
        chk("ramp_dir", int'(dir), 0);
        chk("ramp_errs", int'({err_shape, err_step, err_stall}), 0);

        // Up to 5, down to 3, up again.
        step(16'h0000, 1'b0, 1'b1);
        revs = 0;
        for (int k = 1; k <= 5; k++) step(therm(k), 1'b0, 1'b0);
        step(therm(4), 1'b0, 1'b0); revs += int'(reversal);
        step(therm(3), 1'b0, 1'b0); revs += int'(reversal);
        step(therm(4), 1'b0, 1'b0); revs += int'(reversal);
        chk("rev_count", revs, 2);
        chk("rev_peak", int'(peak_level), 5);
        chk("rev_trough", int'(trough_level), 3);
        chk("rev_dir", int'(dir), 1);

        // Non-thermometer sample, then clear.
        step(16'h0000, 1'b0, 1'b1);
        step(16'h0001, 1'b0, 1'b0);
        step(16'h0003, 1'b0, 1'b0);
        step(16'h0005, 1'b0, 1'b0);
        chk("shape_flag", int'(err_shape), 1);
        chk("shape_dir", int'(dir), 3);
        chk("shape_level", int'(level), 2);
        step(16'h0007, 1'b0, 1'b0);
        chk("fault_hold", int'(level), 2);
        step(16'h0000, 1'b1, 1'b0);
        chk("clr_dir", int'(dir), 0);
        chk("clr_shape", int'(err_shape), 0);
        step(16'h0009, 1'b1, 1'b0);
        chk("clr_bad_dir", int'(dir), 3);
        chk("clr_bad_shape", int'(err_shape), 1);

        // Step jump.
        step(16'h0000, 1'b0, 1'b1);
        step(16'h0001, 1'b0, 1'b0);
        step(16'h0003, 1'b0, 1'b0);
        step(16'h000F, 1'b0, 1'b0);
        chk("jump_flag", int'(err_step), 1);
        chk("jump_level", int'(level), 4);
        chk("jump_dir", int'(dir), 3);

        // Stall after eight repeats.
        step(16'h0000, 1'b0, 1'b1);
        for (int k = 1; k <= 3; k++) step(therm(k), 1'b0, 1'b0);
        for (int n = 1; n <= 7; n++) step(16'h0007, 1'b0, 1'b0);
        chk("stall_early", int'(err_stall), 0);
        step(16'h0007, 1'b0, 1'b0);
        chk("stall_flag", int'(err_stall), 1);
        chk("stall_dir", int'(dir), 3);

        // Reset mid-sequence, and reset beating clr.
        step(16'h0000, 1'b0, 1'b1);
        for (int k = 1; k <= 11; k++) step(therm(k), 1'b0, 1'b0);
        step(therm(10), 1'b0, 1'b0);
        chk("pre_rst_dir", int'(dir), 2);
        step(therm(10), 1'b0, 1'b1);
        chk("rst_level", int'(level), 0);
        chk("rst_peak", int'(peak_level), 0);
        chk("rst_cnt", int'(seq_cnt), 0);
        step(16'h0001, 1'b0, 1'b0);
        chk("post_rst_level", int'(level), 1);
        chk("post_rst_dir", int'(dir), 1);
        step(16'h0005, 1'b0, 1'b0);
        step(16'h0003, 1'b1, 1'b1);
        chk("rst_wins_dir", int'(dir), 0);
        chk("rst_wins_level", int'(level), 0);

        // Saturating sequence counter.
        for (int n = 0; n < 18; n++) begin
            step(therm(1), 1'b0, 1'b0);
            step(therm(2), 1'b0, 1'b0);
            step(therm(1), 1'b0, 1'b0);
            step(therm(0), 1'b0, 1'b0);
        end
        chk("cnt_saturate", int'(seq_cnt), (1 << CNT_W) - 1);
        step(16'h0000, 1'b1, 1'b0);
        chk("clr_keeps_cnt", int'(seq_cnt), (1 << CNT_W) - 1);
        chk("clr_keeps_peak", int'(peak_level), 2);

        // Randomized walk.
        step(16'h0000, 1'b0, 1'b1);
        g = 0;
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 40 && g < 16) g++;
            else if (r < 75 && g > 0) g--;
            s = therm(g);
            if (r >= 90 && r < 94) s = 16'($urandom);
            else if (r >= 94 && r < 97) begin
                g = $urandom_range(0, 16);
                s = therm(g);
            end
            if (m_mode == 3 && $urandom_range(0, 3) == 0) begin
                step(s, 1'b1, 1'b0);
            end else if ($urandom_range(0, 199) == 0) begin
                g = 0;
                step(s, $urandom_range(0, 1) == 1, 1'b1);
            end else begin
                step(s, r >= 97, 1'b0);
            end
            if (lamp_count(int'(s)) >= 0) g = lamp_count(int'(s));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
